tlp_axis_formatter: RTL and testbench

Downstream consumer of the TLP request bus driven by the DMA write engine. Arbitrates one TLP at a time via req_to_send/grant, builds the PCIe header, and serializes header plus payload onto a 64-bit AXI4-Stream toward the PCIe hard-core transmit port. It realigns payload DWs behind 3DW headers, where data straddles beat boundaries.

---
 rtl/tlp_fmt_pkg.sv | 54 +++++
 rtl/tlp_axis_out_reg.sv | 47 ++++
 rtl/tlp_axis_formatter.sv | 169 ++++++++++++++++
 tb/tb_tlp_axis_formatter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_fmt_pkg.sv
// TLP formatter shared types: fmt_type codes, FSM states,
// and PCIe header DW builders.
package tlp_fmt_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;

  localparam logic [6:0] MWR32 = 7'h40;
  localparam logic [6:0] MWR64 = 7'h60;
  localparam logic [6:0] MRD32 = 7'h00;
  localparam logic [6:0] CPLD  = 7'h4A;

  localparam logic [4:0] TYPE_CPL = 5'b01010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_FLUSH
  } fmt_state_e;

  function automatic logic [31:0] build_dw0(
    input logic [6:0] ft,
    input logic [2:0] tc,
    input logic [1:0] at,
    input logic [9:0] len
  );
    return {1'b0, ft, 1'b0, tc, 4'b0, 2'b00, at, 2'b00, len};
  endfunction

  function automatic logic [31:0] build_req_dw1(
    input logic [23:0] tid,
    input logic [7:0]  be
  );
    return {tid, be};
  endfunction

  function automatic logic [31:0] build_cpl_dw1(
    input logic [15:0] cid,
    input logic [11:0] bc
  );
    return {cid, 3'b000, 1'b0, bc};
  endfunction

  function automatic logic [31:0] build_cpl_dw2(
    input logic [23:0] tid,
    input logic [6:0]  la
  );
    return {tid, 1'b0, la};
  endfunction

endpackage

// File: rtl/tlp_axis_out_reg.sv
// Single-entry AXI4-Stream output register; refills on the
// same cycle its current beat is taken.
module tlp_axis_out_reg
  import tlp_fmt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [KEEP_W-1:0] i_keep,
  input  logic              i_last,
  input  logic              i_tready,
  output logic              o_tvalid,
  output logic [DATA_W-1:0] o_tdata,
  output logic [KEEP_W-1:0] o_tkeep,
  output logic              o_tlast,
  output logic              o_can_load
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;
  logic              r_last;

  assign o_can_load = !r_valid || i_tready;
  assign o_tvalid   = r_valid;
  assign o_tdata    = r_data;
  assign o_tkeep    = r_keep;
  assign o_tlast    = r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
    end else if (i_tready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tlp_axis_formatter.sv
// Grants one TLP at a time, builds its header and streams
// header plus payload as 64-bit AXIS beats, realigning 3DW.
module tlp_axis_formatter
  import tlp_fmt_pkg::*;
#(
  parameter logic [2:0] TC = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_to_send,
  output logic        grant,
  input  logic [6:0]  fmt_type,
  input  logic [9:0]  length_in_dw,
  input  logic        src_rdy_n,
  output logic        dst_rdy_n,
  input  logic [63:0] data,
  input  logic [61:0] address,
  input  logic [7:0]  ldwbe_fdwbe,
  input  logic [1:0]  attr,
  input  logic [23:0] transaction_id,
  input  logic [12:0] byte_count,
  input  logic [6:0]  lower_address,
  input  logic [15:0] cfg_completer_id,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast
);

  fmt_state_e  r_state, w_next;
  logic        r_grant;
  logic [31:0] r_dw0, r_dw1, r_dw2, r_dw3, r_held;
  logic        r_hdr4, r_has_data;
  logic [7:0]  r_keep;
  logic [10:0] r_rem;

  logic        w_can_load, w_need_data, w_load, w_last;
  logic [63:0] w_tdata;
  logic [7:0]  w_tkeep;
  logic [10:0] w_rem_after;
  logic        w_hdr4, w_has_data, w_cpl, w_odd;
  logic [31:0] w_alo;
  logic        w_unused;

  assign w_hdr4     = fmt_type[5];
  assign w_has_data = fmt_type[6];
  assign w_cpl      = (fmt_type[4:0] == TYPE_CPL);
  assign w_alo      = {address[29:0], 2'b00};
  assign w_odd      = w_has_data ? (length_in_dw[0] ^ !w_hdr4)
                                 : !w_hdr4;
  assign w_unused   = byte_count[12];

  assign grant     = r_grant;
  assign dst_rdy_n = !(w_need_data && w_can_load);

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_need_data = 1'b0;
    w_tdata     = '0;
    w_tkeep     = 8'hFF;
    w_last      = 1'b0;
    w_rem_after = r_rem;
    unique case (r_state)
      S_IDLE: if (req_to_send && w_can_load) w_next = S_GRANT;
      S_GRANT: w_next = S_HDR0;
      S_HDR0: begin
        w_tdata = {r_dw1, r_dw0};
        w_load  = w_can_load;
        if (w_can_load) w_next = S_HDR1;
      end
      S_HDR1: begin
        if (!r_has_data) begin
          w_tdata = r_hdr4 ? {r_dw3, r_dw2} : {32'h0, r_dw2};
          w_tkeep = r_keep;
          w_last  = 1'b1;
          w_load  = w_can_load;
          if (w_can_load) w_next = S_IDLE;
        end else if (r_hdr4) begin
          w_tdata = {r_dw3, r_dw2};
          w_load  = w_can_load;
          if (w_can_load) w_next = S_DATA;
        end else begin
          w_need_data = 1'b1;
          w_tdata     = {data[31:0], r_dw2};
          w_rem_after = r_rem - 11'd1;
          w_load      = w_can_load && !src_rdy_n;
        end
      end
      S_DATA: begin
        w_need_data = 1'b1;
        w_tdata     = r_hdr4 ? data : {data[31:0], r_held};
        w_rem_after = (r_rem > 11'd2) ? r_rem - 11'd2 : 11'd0;
        w_load      = w_can_load && !src_rdy_n;
      end
      S_FLUSH: begin
        w_tdata = {32'h0, r_held};
        w_tkeep = r_keep;
        w_last  = 1'b1;
        w_load  = w_can_load;
        if (w_can_load) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // A lone leftover DW on the 3DW path goes out as a FLUSH beat
    if (w_need_data) begin
      w_last  = (w_rem_after == 11'd0);
      w_tkeep = w_last ? r_keep : 8'hFF;
      if (w_load)
        w_next = w_last ? S_IDLE :
                 (!r_hdr4 && w_rem_after == 11'd1) ? S_FLUSH :
                 S_DATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= 1'b0;
      r_dw0      <= '0;
      r_dw1      <= '0;
      r_dw2      <= '0;
      r_dw3      <= '0;
      r_held     <= '0;
      r_hdr4     <= 1'b0;
      r_has_data <= 1'b0;
      r_keep     <= '0;
      r_rem      <= '0;
    end else begin
      r_state <= w_next;
      r_grant <= (w_next == S_GRANT);
      if (r_state == S_GRANT) begin
        r_dw0      <= build_dw0(fmt_type, TC, attr, length_in_dw);
        r_dw1      <= w_cpl
                      ? build_cpl_dw1(cfg_completer_id, byte_count[11:0])
                      : build_req_dw1(transaction_id, ldwbe_fdwbe);
        r_dw2      <= w_cpl ? build_cpl_dw2(transaction_id, lower_address)
                      : w_hdr4 ? address[61:30] : w_alo;
        r_dw3      <= w_alo;
        r_hdr4     <= w_hdr4;
        r_has_data <= w_has_data;
        r_keep     <= w_odd ? 8'h0F : 8'hFF;
        r_rem      <= (length_in_dw == 10'd0) ? 11'd1024
                                              : {1'b0, length_in_dw};
      end
      if (w_load && w_need_data) begin
        r_rem  <= w_rem_after;
        r_held <= data[63:32];
      end
    end
  end

  tlp_axis_out_reg u_out (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_data    (w_tdata),
    .i_keep    (w_tkeep),
    .i_last    (w_last),
    .i_tready  (m_axis_tready),
    .o_tvalid  (m_axis_tvalid),
    .o_tdata   (m_axis_tdata),
    .o_tkeep   (m_axis_tkeep),
    .o_tlast   (m_axis_tlast),
    .o_can_load(w_can_load)
  );

endmodule

// File: tb/tb_tlp_axis_formatter.sv
// Scoreboard bench: directed TLPs push hand-computed beats,
// a monitor pops and compares every accepted AXIS beat.
module tb_tlp_axis_formatter;
  import tlp_fmt_pkg::*;

  logic        clk, reset, req_to_send, grant;
  logic [6:0]  fmt_type;
  logic [9:0]  length_in_dw;
  logic        src_rdy_n, dst_rdy_n;
  logic [63:0] data;
  logic [61:0] address;
  logic [7:0]  ldwbe_fdwbe;
  logic [1:0]  attr;
  logic [23:0] transaction_id;
  logic [12:0] byte_count;
  logic [6:0]  lower_address;
  logic [15:0] cfg_completer_id;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] pay[$];
  int          checks, errors;
  logic        skip, fin, stall_mode;

  tlp_axis_formatter #(.TC(3'd0)) dut (
    .clk(clk), .reset(reset),
    .req_to_send(req_to_send), .grant(grant),
    .fmt_type(fmt_type), .length_in_dw(length_in_dw),
    .src_rdy_n(src_rdy_n), .dst_rdy_n(dst_rdy_n),
    .data(data), .address(address),
    .ldwbe_fdwbe(ldwbe_fdwbe), .attr(attr),
    .transaction_id(transaction_id),
    .byte_count(byte_count), .lower_address(lower_address),
    .cfg_completer_id(cfg_completer_id),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = stall_mode ? ~m_axis_tready : 1'b1;
    end
  end

  // Monitor: sole owner of the check/error counters
  initial begin
    beat_t e;
    logic  pg;
    checks = 0;
    errors = 0;
    pg     = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (!fin) begin
        if (reset) begin
          checks++;
          if (m_axis_tvalid || m_axis_tlast || grant || !dst_rdy_n ||
              m_axis_tdata != 64'h0 || m_axis_tkeep != 8'h0) begin
            errors++;
            $display("FAIL reset_state: tvalid=%b tlast=%b grant=%b dst_rdy_n=%b tdata=%h tkeep=%h, required 0 0 0 1 0 00",
                     m_axis_tvalid, m_axis_tlast, grant, dst_rdy_n,
                     m_axis_tdata, m_axis_tkeep);
          end
          pg = 1'b0;
        end else begin
          if (grant) begin
            checks++;
            if (pg) begin
              errors++;
              $display("FAIL grant_pulse: grant=1 two cycles running, required one cycle");
            end
          end
          pg = grant;
          if (m_axis_tvalid && !m_axis_tready) begin
            checks++;
            if (!dst_rdy_n) begin
              errors++;
              $display("FAIL stall_dst_rdy: dst_rdy_n=%b, required 1", dst_rdy_n);
            end
          end else if (m_axis_tvalid && !skip) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL extra_beat: got %h keep %h last %b, required no beat",
                       m_axis_tdata, m_axis_tkeep, m_axis_tlast);
            end else begin
              e = exp_q.pop_front();
              if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k ||
                  m_axis_tlast !== e.l) begin
                errors++;
                $display("FAIL beat: got %h keep %h last %b, required %h keep %h last %b",
                         m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                         e.d, e.k, e.l);
              end
            end
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic expb(input logic [63:0] d, input logic [7:0] k,
                      input logic l);
    beat_t b;
    b.d = d;
    b.k = k;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic send(
    input logic [6:0]  ft,
    input logic [9:0]  len,
    input logic [63:0] baddr,
    input logic [23:0] tid,
    input logic [7:0]  be,
    input logic [1:0]  at,
    input logic [12:0] bc,
    input logic [6:0]  la,
    input logic [15:0] cid,
    input int          nfeed
  );
    int n;
    fmt_type         = ft;
    length_in_dw     = len;
    address          = baddr[63:2];
    transaction_id   = tid;
    ldwbe_fdwbe      = be;
    attr             = at;
    byte_count       = bc;
    lower_address    = la;
    cfg_completer_id = cid;
    req_to_send      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!grant && n < 300);
    if (!grant) begin
      $display("FAIL grant_timeout: grant=0 after %0d cycles, required 1", n);
      $fatal(1);
    end
    @(posedge clk); #1;
    req_to_send = 1'b0;
    for (int i = 0; i < nfeed; i++) begin
      data      = pay[i];
      src_rdy_n = 1'b0;
      n = 0;
      @(negedge clk);
      while (dst_rdy_n && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (dst_rdy_n) begin
        $display("FAIL data_timeout: dst_rdy_n=1 at beat %0d, required 0", i);
        $fatal(1);
      end
      @(posedge clk); #1;
    end
    src_rdy_n = 1'b1;
    data      = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++)
      @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    fin = 1'b0; skip = 1'b0; stall_mode = 1'b0;
    reset = 1'b1; req_to_send = 1'b0; src_rdy_n = 1'b1;
    fmt_type = '0; length_in_dw = '0; data = '0; address = '0;
    ldwbe_fdwbe = '0; attr = '0; transaction_id = '0;
    byte_count = '0; lower_address = '0; cfg_completer_id = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // MWr32 len 1
    expb(64'h0100_050F_4000_0001, 8'hFF, 1'b0);
    expb(64'hCAFE_0001_1000_0010, 8'hFF, 1'b1);
    pay = {64'h0000_0000_CAFE_0001};
    send(MWR32, 10'd1, 64'h1000_0010, 24'h010005, 8'h0F,
         2'b00, 13'd0, 7'd0, 16'h0, 1);

    // MWr64 len 4
    expb(64'h0100_06FF_6000_0004, 8'hFF, 1'b0);
    expb(64'h2345_6780_0000_0001, 8'hFF, 1'b0);
    expb(64'h2222_2222_1111_1111, 8'hFF, 1'b0);
    expb(64'h4444_4444_3333_3333, 8'hFF, 1'b1);
    pay = {64'h2222_2222_1111_1111, 64'h4444_4444_3333_3333};
    send(MWR64, 10'd4, 64'h1_2345_6780, 24'h010006, 8'hFF,
         2'b00, 13'd0, 7'd0, 16'h0, 2);

    // MWr32 len 2: held DW goes out in a flush beat
    expb(64'h0100_07FF_4000_0002, 8'hFF, 1'b0);
    expb(64'h0000_000A_2000_0040, 8'hFF, 1'b0);
    expb(64'h0000_0000_0000_000B, 8'h0F, 1'b1);
    pay = {64'h0000_000B_0000_000A};
    send(MWR32, 10'd2, 64'h2000_0040, 24'h010007, 8'hFF,
         2'b00, 13'd0, 7'd0, 16'h0, 1);

    // CplD len 1, attr 01
    expb(64'h0100_0004_4A00_1001, 8'hFF, 1'b0);
    expb(64'h1234_5678_0100_2A04, 8'hFF, 1'b1);
    pay = {64'h0000_0000_1234_5678};
    send(CPLD, 10'd1, 64'h0, 24'h01002A, 8'h00,
         2'b01, 13'd4, 7'h04, 16'h0100, 1);

    // MRd32: header only, tlast on second beat
    expb(64'h0100_090F_0000_0001, 8'hFF, 1'b0);
    expb(64'h0000_0000_4000_0100, 8'h0F, 1'b1);
    send(MRD32, 10'd1, 64'h4000_0100, 24'h010009, 8'h0F,
         2'b00, 13'd0, 7'd0, 16'h0, 0);
    drain();

    // MWr32 len 5 with alternating tready
    stall_mode = 1'b1;
    expb(64'h0100_08FF_4000_0005, 8'hFF, 1'b0);
    expb(64'h5000_0000_3000_0000, 8'hFF, 1'b0);
    expb(64'h5000_0002_5000_0001, 8'hFF, 1'b0);
    expb(64'h5000_0004_5000_0003, 8'hFF, 1'b1);
    pay = {64'h5000_0001_5000_0000, 64'h5000_0003_5000_0002,
           64'h0000_0000_5000_0004};
    send(MWR32, 10'd5, 64'h3000_0000, 24'h010008, 8'hFF,
         2'b00, 13'd0, 7'd0, 16'h0, 3);
    drain();
    stall_mode = 1'b0;
    @(posedge clk); #1;

    // Reset while in DATA of a len-8 MWr32; partial TLP dropped
    skip = 1'b1;
    pay = {64'h6000_0001_6000_0000, 64'h6000_0003_6000_0002};
    send(MWR32, 10'd8, 64'h5000_0000, 24'h01000A, 8'hFF,
         2'b00, 13'd0, 7'd0, 16'h0, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    skip  = 1'b0;
    @(posedge clk); #1;

    // Post-reset TLP must be intact
    expb(64'h0100_050F_4000_0001, 8'hFF, 1'b0);
    expb(64'hCAFE_0001_1000_0010, 8'hFF, 1'b1);
    pay = {64'h0000_0000_CAFE_0001};
    send(MWR32, 10'd1, 64'h1000_0010, 24'h010005, 8'h0F,
         2'b00, 13'd0, 7'd0, 16'h0, 1);
    drain();
    repeat (3) @(posedge clk);
    fin = 1'b1;
  end

endmodule
